// File: rtl/lem_dig_arbiter.sv
// lem_dig_arbiter
// Round-robin arbiter that shares the single dig tool among N lemming walker FSMs.
// One lemming holds the tool at a time, for at most MAX_DIG cycles. Each release
// is followed by COOLDOWN cycles with no grant, then arbitration resumes. The
// lemming just released is placed last in priority.
//
// Ports:
//   clk          rising-edge clock
//   areset       synchronous active-high reset
//   req[N]       bit i: lemming i requests the dig tool
//   ground[N]    bit i: lemming i is on ground (request eligible only when both set)
//   grant[N]     registered one-hot (or zero) grant
//   grant_valid  registered OR of grant
//   grant_id     index of the granted lemming, holds its last value while idle
//   dig_cycles   cycles the current grant has been held (1 in first cycle, 0 idle)
//   timeout      one-cycle pulse in the cycle after a grant is cut by MAX_DIG

module lem_dig_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_DIG  = 16,
    parameter int unsigned COOLDOWN = 2,
    localparam int unsigned IdW     = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned CntW    = $clog2(MAX_DIG + 1)
) (
    input  logic            clk,
    input  logic            areset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    ground,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IdW-1:0]  grant_id,
    output logic [CntW-1:0] dig_cycles,
    output logic            timeout
);

    localparam int unsigned CoolW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StCool  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic            grant_valid_q, grant_valid_d;
    logic [IdW-1:0]  grant_id_q, grant_id_d;
    logic [CntW-1:0] dig_cycles_q, dig_cycles_d;
    logic            timeout_q, timeout_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [CoolW-1:0] cool_q, cool_d;

    logic [N-1:0]    elig;
    logic            pick_found;
    logic [IdW-1:0]  pick_id;
    logic [IdW-1:0]  scan_id;
    int unsigned     scan_idx;
    logic            arb_en;
    logic            do_release;
    logic            release_timeout;
    logic [IdW-1:0]  ptr_next;

    assign elig = req & ground;

    // First eligible index scanning ptr, ptr+1, ... modulo N.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = 0;
        scan_id    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            scan_idx = (32'(ptr_q) + i) % N;
            scan_id  = IdW'(scan_idx);
            if (!pick_found && elig[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    // Wrap explicitly at N so a non-power-of-two N never yields an index >= N.
    always_comb begin
        if (32'(grant_id_q) == N - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_id_q + IdW'(1);
        end
    end

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        grant_id_d      = grant_id_q;
        dig_cycles_d    = dig_cycles_q;
        timeout_d       = 1'b0;
        ptr_d           = ptr_q;
        cool_d          = cool_q;
        arb_en          = 1'b0;
        do_release      = 1'b0;
        release_timeout = 1'b0;

        unique case (state_q)
            StIdle: begin
                arb_en = 1'b1;
            end
            StGrant: begin
                if (!elig[grant_id_q]) begin
                    do_release = 1'b1;
                end else if (32'(dig_cycles_q) == MAX_DIG) begin
                    do_release      = 1'b1;
                    release_timeout = 1'b1;
                end else begin
                    dig_cycles_d = dig_cycles_q + CntW'(1);
                end
            end
            StCool: begin
                // The edge on which the counter reaches zero closes the cooldown
                // and arbitrates, so grant stays low for exactly COOLDOWN cycles.
                cool_d = cool_q - CoolW'(1);
                if (cool_q <= CoolW'(1)) begin
                    cool_d  = '0;
                    state_d = StIdle;
                    arb_en  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_release) begin
            grant_d      = '0;
            dig_cycles_d = '0;
            ptr_d        = ptr_next;
            timeout_d    = release_timeout;
            if (COOLDOWN > 0) begin
                state_d = StCool;
                cool_d  = CoolW'(COOLDOWN);
            end else begin
                state_d = StIdle;
            end
        end

        if (arb_en && pick_found) begin
            grant_d          = '0;
            grant_d[pick_id] = 1'b1;
            grant_id_d       = pick_id;
            dig_cycles_d     = CntW'(1);
            state_d          = StGrant;
        end

        grant_valid_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q       <= StIdle;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            dig_cycles_q  <= '0;
            timeout_q     <= 1'b0;
            ptr_q         <= '0;
            cool_q        <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            dig_cycles_q  <= dig_cycles_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            cool_q        <= cool_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign dig_cycles  = dig_cycles_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_lem_dig_arbiter.sv
// Testbench for lem_dig_arbiter (N=4, MAX_DIG=4, COOLDOWN=2).
// A behavioural model computes the expected outputs for each edge when the
// inputs are driven; they are queued and compared after the edge.

module tb_lem_dig_arbiter;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_DIG  = 4;
    localparam int unsigned COOLDOWN = 2;
    localparam int unsigned IdW      = 2;
    localparam int unsigned CntW     = 3;

    logic            clk;
    logic            areset;
    logic [N-1:0]    req;
    logic [N-1:0]    ground;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [IdW-1:0]  grant_id;
    logic [CntW-1:0] dig_cycles;
    logic            timeout;

    lem_dig_arbiter #(
        .N        (N),
        .MAX_DIG  (MAX_DIG),
        .COOLDOWN (COOLDOWN)
    ) dut (
        .clk         (clk),
        .areset      (areset),
        .req         (req),
        .ground      (ground),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .dig_cycles  (dig_cycles),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]    grant;
        logic            gv;
        logic [IdW-1:0]  id;
        logic [CntW-1:0] dig;
        logic            to;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_passed = 0;

    // Model state
    int m_busy = 0;
    int m_id   = 0;
    int m_dig  = 0;
    int m_ptr  = 0;
    int m_wait = 0;   // remaining low cycles after a release
    int m_to   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end else begin
            n_passed++;
        end
    endtask

    task automatic model_edge(input logic rst, input logic [N-1:0] r, input logic [N-1:0] g);
        logic [N-1:0] e;
        int j;
        e    = r & g;
        m_to = 0;
        if (rst) begin
            m_busy = 0; m_id = 0; m_dig = 0; m_ptr = 0; m_wait = 0;
        end else if (m_busy != 0) begin
            if (e[m_id] == 1'b0 || m_dig == MAX_DIG) begin
                m_to   = (e[m_id] == 1'b1) ? 1 : 0;
                m_busy = 0;
                m_dig  = 0;
                m_ptr  = (m_id + 1) % N;
                m_wait = COOLDOWN;
            end else begin
                m_dig++;
            end
        end else if (m_wait > 1) begin
            m_wait--;
        end else begin
            m_wait = 0;
            for (int i = 0; i < N; i++) begin
                j = (m_ptr + i) % N;
                if (m_busy == 0 && e[j]) begin
                    m_busy = 1;
                    m_id   = j;
                    m_dig  = 1;
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic [N-1:0] r, input logic [N-1:0] g);
        exp_t e;
        logic [N-1:0] one;
        one    = 1;
        areset = rst;
        req    = r;
        ground = g;
        model_edge(rst, r, g);
        e.grant = (m_busy != 0) ? (one << m_id) : '0;
        e.gv    = (m_busy != 0);
        e.id    = IdW'(m_id);
        e.dig   = CntW'(m_dig);
        e.to    = (m_to != 0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("grant",       32'(grant),       32'(e.grant));
        check("grant_valid", 32'(grant_valid), 32'(e.gv));
        check("grant_id",    32'(grant_id),    32'(e.id));
        check("dig_cycles",  32'(dig_cycles),  32'(e.dig));
        check("timeout",     32'(timeout),     32'(e.to));
        check("gv_or",       32'(grant_valid), 32'(|grant));
        check("onehot",      32'($countones(grant) <= 1), 32'(1));
    endtask

    initial begin
        areset = 1'b1;
        req    = '0;
        ground = '1;

        step(1'b1, 4'b0000, 4'b1111);
        step(1'b1, 4'b0000, 4'b1111);

        // Idle after reset
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'b1111);
        check("idle_grant", 32'(grant), 32'(0));

        // Drop after two cycles, cooldown ignores req[2], then lemming 2
        step(1'b0, 4'b0101, 4'b1111);
        check("t2_first", 32'(grant), 32'(4'b0001));
        step(1'b0, 4'b0101, 4'b1111);
        check("t2_dig2", 32'(dig_cycles), 32'(2));
        step(1'b0, 4'b0100, 4'b1111);
        step(1'b0, 4'b0100, 4'b1111);
        check("t2_cool", 32'(grant), 32'(0));
        step(1'b0, 4'b0100, 4'b1111);
        check("t2_grant2", 32'(grant), 32'(4'b0100));
        check("t2_id2", 32'(grant_id), 32'(2));
        check("t2_noto", 32'(timeout), 32'(0));
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 4'b1111);

        // Continuous request hits MAX_DIG
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0010, 4'b1111);
        check("t3_dig4", 32'(dig_cycles), 32'(4));
        step(1'b0, 4'b0010, 4'b1111);
        check("t3_timeout", 32'(timeout), 32'(1));
        check("t3_cut", 32'(grant), 32'(0));
        step(1'b0, 4'b0010, 4'b1111);
        check("t3_to_once", 32'(timeout), 32'(0));
        step(1'b0, 4'b0010, 4'b1111);
        check("t3_regrant", 32'(grant), 32'(4'b0010));
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 4'b1111);

        // Lemming 3 loses ground mid-grant
        step(1'b0, 4'b1000, 4'b1111);
        check("t4_grant3", 32'(grant), 32'(4'b1000));
        step(1'b0, 4'b1000, 4'b1111);
        step(1'b0, 4'b1000, 4'b0111);
        check("t4_drop", 32'(grant), 32'(0));
        check("t4_noto", 32'(timeout), 32'(0));
        step(1'b0, 4'b1111, 4'b1111);
        step(1'b0, 4'b1111, 4'b1111);
        check("t4_wrap0", 32'(grant), 32'(4'b0001));

        // Full contention rotation
        for (int i = 0; i < 30; i++) step(1'b0, 4'b1111, 4'b1111);

        // Reset mid-grant and held
        while (dig_cycles != 3'd2) step(1'b0, 4'b1111, 4'b1111);
        step(1'b1, 4'b1111, 4'b1111);
        check("t6_rst_grant", 32'(grant), 32'(0));
        check("t6_rst_dig", 32'(dig_cycles), 32'(0));
        for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 4'b1111);
        step(1'b0, 4'b1111, 4'b1111);
        check("t6_after_rst", 32'(grant), 32'(4'b0001));

        // Random traffic with occasional reset
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) == 0), N'($urandom), N'($urandom | $urandom));
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
